// File: rtl/rs232_rx_ctrl_if.sv
// rtl/rs232_rx_ctrl_if.sv - serial line input and receive-sequencer status/data bundle
interface rs232_rx_ctrl_if;
  logic       i_rx_pin;
  logic       i_rx_en;
  logic       o_rs232_busy;
  logic [3:0] o_ctrl_cnt;
  logic       o_bit_tick;
  logic [7:0] o_rx_data;
  logic       o_rx_valid;
  logic       o_frame_err;

  modport master (
    output i_rx_pin, i_rx_en,
    input  o_rs232_busy, o_ctrl_cnt, o_bit_tick, o_rx_data, o_rx_valid, o_frame_err
  );

  modport slave (
    input  i_rx_pin, i_rx_en,
    output o_rs232_busy, o_ctrl_cnt, o_bit_tick, o_rx_data, o_rx_valid, o_frame_err
  );
endinterface

// File: rtl/rs232_rx_ctrl.sv
// rtl/rs232_rx_ctrl.sv - RS232 receive sequencer and byte assembler (optional even parity: RS232_RX_PARITY_EN)
module rs232_rx_ctrl #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic           clk_ref,
  input  logic           rst_n,
  rs232_rx_ctrl_if.slave bus
);
  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int HALF_DIV = BAUD_DIV / 2;
  localparam int CW       = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] CNT_MID  = CW'(HALF_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);

`ifdef RS232_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
  localparam logic [3:0] CNT_AFTER_D7 = 4'd10;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
  localparam logic [3:0] CNT_AFTER_D7 = 4'd9;
`endif

  state_t          state, state_nxt;
  logic            sync1, sync2, sync3;
  logic            line, fall, tick, stop_ok;
  logic [CW-1:0]   baud_cnt;
  logic [3:0]      ctrl_cnt;
  logic [7:0]      shift_reg;
  logic [7:0]      rx_data;
  logic            rx_valid, frame_err, busy, bit_tick;
`ifdef RS232_RX_PARITY_EN
  logic            parity_ok;
  assign stop_ok = line & parity_ok;
`else
  assign stop_ok = line;
`endif

  assign line = sync2;
  assign fall = sync3 & ~sync2;

  assign bus.o_rs232_busy = busy;
  assign bus.o_ctrl_cnt   = ctrl_cnt;
  assign bus.o_bit_tick   = bit_tick;
  assign bus.o_rx_data    = rx_data;
  assign bus.o_rx_valid   = rx_valid;
  assign bus.o_frame_err  = frame_err;

  // Two-flop synchroniser plus a delay flop for falling-edge detection; idles high.
  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) {sync3, sync2, sync1} <= 3'b111;
    else        {sync3, sync2, sync1} <= {sync2, sync1, bus.i_rx_pin};
  end

  // State register.
  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state, bit-midpoint tick and busy; a start bit that fails its midpoint check is silent.
  always_comb begin
    state_nxt = state;
    tick      = 1'b0;
    busy      = 1'b0;
    bit_tick  = 1'b0;
    case (state)
      S_IDLE: if (fall && bus.i_rx_en) state_nxt = S_START;
      S_START: begin
        busy     = 1'b1;
        tick     = (baud_cnt == CNT_MID);
        bit_tick = tick & ~line;
        if (tick) state_nxt = line ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        busy     = 1'b1;
        tick     = (baud_cnt == CNT_LAST);
        bit_tick = tick;
`ifdef RS232_RX_PARITY_EN
        if (tick && ctrl_cnt == 4'd8) state_nxt = S_PARITY;
`else
        if (tick && ctrl_cnt == 4'd8) state_nxt = S_STOP;
`endif
      end
`ifdef RS232_RX_PARITY_EN
      S_PARITY: begin
        busy     = 1'b1;
        tick     = (baud_cnt == CNT_LAST);
        bit_tick = tick;
        if (tick) state_nxt = S_STOP;
      end
`endif
      S_STOP: begin
        busy     = 1'b1;
        tick     = (baud_cnt == CNT_LAST);
        bit_tick = tick;
        // A held-low stop bit is a break; a parity-only failure sees the line high and idles.
        if (tick) state_nxt = line ? S_IDLE : S_BREAK;
      end
      S_BREAK: if (line) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Baud counter, bit index, shift register and the result registers.
  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt  <= '0;
      ctrl_cnt  <= 4'd0;
      shift_reg <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef RS232_RX_PARITY_EN
      parity_ok <= 1'b1;
`endif
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      // Held at zero outside a frame so START always begins counting from 0.
      if (state == S_IDLE || state == S_BREAK || tick) baud_cnt <= '0;
      else                                             baud_cnt <= baud_cnt + CW'(1);
      if (tick) begin
        case (state)
          S_START: ctrl_cnt <= line ? 4'd0 : 4'd1;
          S_DATA: begin
            shift_reg <= {line, shift_reg[7:1]};
            ctrl_cnt  <= (ctrl_cnt == 4'd8) ? CNT_AFTER_D7 : ctrl_cnt + 4'd1;
          end
`ifdef RS232_RX_PARITY_EN
          S_PARITY: begin
            parity_ok <= (line == ^shift_reg);
            ctrl_cnt  <= 4'd9;
          end
`endif
          S_STOP: begin
            ctrl_cnt <= 4'd0;
            if (stop_ok) begin
              rx_data  <= shift_reg;
              rx_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rs232_rx_ctrl.sv
// tb/tb_rs232_rx_ctrl.sv - directed self-checking bench for rs232_rx_ctrl
`timescale 1ns/1ps
module tb_rs232_rx_ctrl;
  localparam int BAUD_DIV = 434;
`ifdef RS232_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FRAME_BITS = PAR ? 11 : 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  rs232_rx_ctrl_if bus();

  rs232_rx_ctrl #(.CLK_FREQ(50000000), .BAUD_RATE(115200)) dut (
    .clk_ref(clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor: cumulative event counts and logs, sampled on the falling edge.
  int         cyc = 0;
  int         n_valid = 0, n_err = 0, n_tick = 0, n_both = 0, n_busy_rise = 0;
  int         busy_start = 0, busy_fall_cyc = 0, busy_len = 0;
  logic       busy_q = 1'b0;
  logic [3:0] ctrl_q = 4'd0;
  logic [7:0] vlog_data[$];
  int         vlog_cyc[$];
  int         ctrl_log[$];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.o_rx_valid) begin
      n_valid = n_valid + 1;
      vlog_data.push_back(bus.o_rx_data);
      vlog_cyc.push_back(cyc);
    end
    if (bus.o_frame_err) n_err = n_err + 1;
    if (bus.o_bit_tick) n_tick = n_tick + 1;
    if (bus.o_rx_valid && bus.o_frame_err) n_both = n_both + 1;
    if (bus.o_ctrl_cnt != ctrl_q) begin
      ctrl_log.push_back(int'(bus.o_ctrl_cnt));
      ctrl_q = bus.o_ctrl_cnt;
    end
    if (bus.o_rs232_busy && !busy_q) begin
      n_busy_rise = n_busy_rise + 1;
      busy_start = cyc;
    end
    if (!bus.o_rs232_busy && busy_q) begin
      busy_fall_cyc = cyc;
      busy_len = cyc - busy_start;
    end
    busy_q = bus.o_rs232_busy;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    bus.i_rx_pin = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par_good, input logic stop);
    hold(1'b0, BAUD_DIV);
    for (int i = 0; i < 8; i++) hold(d[i], BAUD_DIV);
    if (PAR) hold((^d) ^ ~par_good, BAUD_DIV);
    hold(stop, BAUD_DIV);
  endtask

  task automatic check_idle_outputs(input string tag, input logic [7:0] exp_data);
    @(negedge clk);
    check({tag, "_busy"},  bus.o_rs232_busy, 0);
    check({tag, "_cnt"},   bus.o_ctrl_cnt, 0);
    check({tag, "_tick"},  bus.o_bit_tick, 0);
    check({tag, "_valid"}, bus.o_rx_valid, 0);
    check({tag, "_err"},   bus.o_frame_err, 0);
    check({tag, "_data"},  bus.o_rx_data, exp_data);
    @(posedge clk); #1;
  endtask

  initial begin
    int s_ctrl, s_tick, s_valid, s_err, s_rise, t0, lat, diff;
    int exp_seq[$];

    bus.i_rx_pin = 1'b1;
    bus.i_rx_en  = 1'b1;
    repeat (3) @(posedge clk);
    check_idle_outputs("reset", 8'h00);
    rst_n = 1'b1;
    hold(1'b1, 50);

    // Test 1: 0x55 8N1 (or with good parity)
    s_ctrl = ctrl_log.size(); s_tick = n_tick; s_valid = n_valid;
    t0 = cyc;
    send_frame(8'h55, 1'b1, 1'b1);
    hold(1'b1, BAUD_DIV);
    for (int i = 1; i <= 8; i++) exp_seq.push_back(i);
    if (PAR) exp_seq.push_back(10);
    exp_seq.push_back(9);
    exp_seq.push_back(0);
    check("t1_cnt_steps", ctrl_log.size() - s_ctrl, exp_seq.size());
    for (int i = 0; i < exp_seq.size(); i++)
      if (s_ctrl + i < ctrl_log.size()) check($sformatf("t1_cnt_%0d", i), ctrl_log[s_ctrl + i], exp_seq[i]);
    check("t1_ticks", n_tick - s_tick, FRAME_BITS);
    check("t1_valid_cnt", n_valid - s_valid, 1);
    check("t1_data", bus.o_rx_data, 8'h55);
    if (vlog_cyc.size() > 0) begin
      diff = busy_fall_cyc - vlog_cyc[$];
      check("t1_busy_low_after_valid", (diff >= 0 && diff <= 1), 1);
      lat = vlog_cyc[$] - t0;
      check("t1_latency_window", (lat >= 4115 + (FRAME_BITS - 10) * BAUD_DIV) &&
                                 (lat <= 4135 + (FRAME_BITS - 10) * BAUD_DIV), 1);
    end

    // Test 2: 100-clock glitch aborts at the start-bit midpoint
    s_ctrl = ctrl_log.size(); s_valid = n_valid; s_err = n_err; s_rise = n_busy_rise;
    hold(1'b0, 100);
    hold(1'b1, 2 * BAUD_DIV);
    check("t2_no_valid", n_valid - s_valid, 0);
    check("t2_no_err", n_err - s_err, 0);
    check("t2_busy_rise", n_busy_rise - s_rise, 1);
    check("t2_busy_len", (busy_len >= 214 && busy_len <= 220), 1);
    check("t2_cnt_quiet", ctrl_log.size() - s_ctrl, 0);
    check("t2_busy_now", bus.o_rs232_busy, 0);

    // Test 3: 0xA3 with low stop bit, line held low two more bit times
    s_valid = n_valid; s_err = n_err; s_rise = n_busy_rise;
    send_frame(8'hA3, 1'b1, 1'b0);
    hold(1'b0, 2 * BAUD_DIV);
    check("t3_busy_in_break", bus.o_rs232_busy, 0);
    hold(1'b1, 2 * BAUD_DIV);
    check("t3_err_cnt", n_err - s_err, 1);
    check("t3_no_valid", n_valid - s_valid, 0);
    check("t3_data_held", bus.o_rx_data, 8'h55);
    check("t3_no_restart", n_busy_rise - s_rise, 1);

    // Test 4: 0xA3 then 0x0F back to back
    s_valid = n_valid;
    send_frame(8'hA3, 1'b1, 1'b1);
    send_frame(8'h0F, 1'b1, 1'b1);
    hold(1'b1, BAUD_DIV);
    check("t4_valid_cnt", n_valid - s_valid, 2);
    if (vlog_data.size() >= s_valid + 2) begin
      check("t4_data0", vlog_data[s_valid], 8'hA3);
      check("t4_data1", vlog_data[s_valid + 1], 8'h0F);
      diff = vlog_cyc[s_valid + 1] - vlog_cyc[s_valid] - FRAME_BITS * BAUD_DIV;
      check("t4_spacing", (diff >= -2 && diff <= 2), 1);
    end

    // Test 5: reset during data bit 4 of 0xFF, then 0x3C
    s_valid = n_valid;
    hold(1'b0, BAUD_DIV);
    for (int i = 0; i < 4; i++) hold(1'b1, BAUD_DIV);
    hold(1'b1, 200);
    check("t5_busy_before_rst", bus.o_rs232_busy, 1);
    rst_n = 1'b0;
    hold(1'b1, 3);
    check_idle_outputs("t5_rst", 8'h00);
    rst_n = 1'b1;
    hold(1'b1, 2 * BAUD_DIV);
    send_frame(8'h3C, 1'b1, 1'b1);
    hold(1'b1, BAUD_DIV);
    check("t5_valid_cnt", n_valid - s_valid, 1);
    check("t5_data", bus.o_rx_data, 8'h3C);

`ifdef RS232_RX_PARITY_EN
    // Test 6: 0x07 with good parity (1), then bad parity (0)
    s_valid = n_valid; s_err = n_err;
    send_frame(8'h07, 1'b1, 1'b1);
    hold(1'b1, BAUD_DIV);
    check("t6_valid", n_valid - s_valid, 1);
    check("t6_data", bus.o_rx_data, 8'h07);
    send_frame(8'h07, 1'b0, 1'b1);
    hold(1'b1, BAUD_DIV);
    check("t6_par_err", n_err - s_err, 1);
    check("t6_no_new_valid", n_valid - s_valid, 1);
    check("t6_data_held", bus.o_rx_data, 8'h07);
`endif

    check("valid_err_exclusive", n_both, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rs232_rx_ctrl.md
Name: rs232_rx_ctrl

Overview:
Receive-side sequencer for the RS232 link. It detects and qualifies the start bit, generates the mid-bit sampling strobe from a baud divider, and steps the frame bit counter 0..9. The `o_rs232_busy` and `o_ctrl_cnt` outputs drive the RX data capture logic. The block also assembles the byte itself and presents it with a one-cycle valid pulse and a framing error flag.

Parameters:
- CLK_FREQ, 50000000, clk_ref frequency in Hz.
- BAUD_RATE, 115200, line rate in bit/s.
- BAUD_DIV, CLK_FREQ/BAUD_RATE, clocks per bit (derived localparam; must be >= 16).
- HALF_DIV, BAUD_DIV/2, clocks from the start-bit falling edge to the start-bit midpoint (derived localparam).

Ports:
- clk_ref  in  1  single system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_rx_pin  in  1  raw serial input, asynchronous to clk_ref, idle high.
- i_rx_en  in  1  receiver enable; when low, a new frame is not started.
- o_rs232_busy  out  1  high while a frame is in progress (START through STOP).
- o_ctrl_cnt  out  4  frame bit index: 0 = idle/start, 1..8 = data bits, 9 = stop (10 = parity, feature only).
- o_bit_tick  out  1  one-cycle strobe at each bit midpoint (start, data, stop).
- o_rx_data  out  8  last correctly received byte; holds until the next good frame.
- o_rx_valid  out  1  one-cycle pulse when o_rx_data is updated.
- o_frame_err  out  1  one-cycle pulse on a bad stop bit (or parity error with the feature).

Behaviour:
- Reset values:
  - All outputs 0, except o_rx_data = 8'h00.
  - State = IDLE, baud counter = 0.
  - Synchroniser flops = 1.
- Input path:
  - i_rx_pin passes through a 2-flop synchroniser plus one delay flop.
  - A falling edge is registered synced 1 -> 0.
  - All line sampling uses the synchronised value.
- Baud counter:
  - Counts 0..BAUD_DIV-1, then wraps.
  - Cleared on entry to START.
  - o_bit_tick fires when the counter reaches HALF_DIV-1 in START, and BAUD_DIV-1 in the later states.
- State machine:
  - IDLE: o_ctrl_cnt = 0, busy = 0. A falling edge with i_rx_en = 1 moves to START.
  - START: busy = 1. At the half-bit tick:
    - line = 0: o_ctrl_cnt <= 1, go to DATA.
    - line = 1 (glitch): go to IDLE with no pulses.
  - DATA: at each tick, shift the sampled bit in LSB-first (`shift_reg <= {line, shift_reg[7:1]}`). o_ctrl_cnt increments. At the tick with o_ctrl_cnt = 8, set o_ctrl_cnt <= 9 and go to STOP.
  - STOP: at the tick:
    - line = 1: o_rx_data <= shift_reg, o_rx_valid pulses the next cycle, go to IDLE.
    - line = 0: o_frame_err pulses, o_rx_data is unchanged, go to BREAK.
  - BREAK: busy = 0, o_ctrl_cnt = 0. Wait for synced line = 1, then go to IDLE.
- Latency: o_rx_valid rises 1 clk after the stop-bit midpoint tick, nominally 9.5*BAUD_DIV + 4 clocks after the raw falling edge.
- Back-to-back frames:
  - A falling edge detected in the IDLE cycle right after STOP is accepted.
  - Edges during the START, DATA and STOP states are ignored.
- i_rx_en deasserted mid-frame: the current frame completes normally.
- Reset mid-frame: immediate return to IDLE, all outputs cleared, and the partial byte is discarded.
- o_rx_valid and o_frame_err are never high in the same cycle.

Optional Feature:
RS232_RX_PARITY_EN:
- Defined: the frame carries an even-parity bit after D7.
  - DATA moves to PARITY with o_ctrl_cnt = 10 at the 8th tick.
  - The parity sample is compared with the XOR of the 8 data bits.
  - STOP is then entered; the valid/err decision there uses stop bit AND parity_ok.
  - A parity mismatch with a good stop bit pulses o_frame_err, leaves o_rx_data unchanged and returns to IDLE (not BREAK).
- Undefined: no PARITY state, o_ctrl_cnt never exceeds 9, and the frame is 8N1.

Test Plan:
1. CLK_FREQ = 50 MHz, BAUD = 115200 (BAUD_DIV = 434), send 8N1 byte 0x55:
   - o_ctrl_cnt steps 0,1..8,9,0.
   - 10 o_bit_tick pulses.
   - o_rx_valid pulses once, o_rx_data = 0x55.
   - busy low within 1 clk after valid.
2. Glitch: line low for 100 clk, then high:
   - START aborts at the half-bit tick.
   - No valid or err pulse; busy high for about 217 clk, then 0.
3. Send 0xA3 with stop bit = 0, line held low 2 bit times, then high:
   - o_frame_err pulses once; o_rx_data keeps its previous value.
   - No new frame is started until the line returns high.
4. Send 0xA3 and 0x0F back-to-back with no idle gap:
   - Two valid pulses, data 0xA3 then 0x0F.
   - Valid pulses 10*434 ±2 clk apart.
5. Assert rst_n = 0 during data bit 4 of 0xFF, then release and send 0x3C:
   - All outputs cleared at reset.
   - Only one valid pulse, with data 0x3C.
6. (RS232_RX_PARITY_EN) Send 0x07 with parity bit = 1:
   - Valid pulse, data 0x07.
   - Resend with parity bit = 0: o_frame_err pulses, data still 0x07.
